ped_crossing_ctrl: RTL
======================

Name: ped_crossing_ctrl

Overview:
Downstream consumer of the vehicle traffic-light FSM's one-hot lights bus {Red, Yellow, Green}. It latches a debounced pedestrian push-button request and grants a crossing only inside a vehicle RED phase: steady WALK, then flashing clearance with a countdown, then steady DON'T WALK. It also checks the lights bus for illegal codes and forces a safe state when it sees one.

Parameters:
DEBOUNCE_CYCLES, 3, consecutive synchronised-high samples needed to accept a button press
WALK_CYCLES, 2, cycles of steady WALK per crossing
FLASH_CYCLES, 3, cycles of flashing clearance after WALK
CNT_W, 4, countdown width; must hold WALK_CYCLES+FLASH_CYCLES-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
lights  input  3  vehicle lights {Red, Yellow, Green} from the light FSM; RED=3'b100
ped_btn  input  1  raw asynchronous pedestrian button, active-high
walk  output  1  steady WALK lamp
dont_walk  output  1  DON'T WALK lamp (steady in IDLE, blinking in CLEAR)
flash  output  1  1 while in CLEAR
countdown  output  CNT_W  remaining crossing cycles; 0 when not crossing
req_pending  output  1  latched, ungranted pedestrian request
abort  output  1  one-cycle pulse when a crossing is cut short
light_fault  output  1  sticky illegal-lights flag

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, walk=0, dont_walk=1, flash=0, countdown=0, req_pending=0, abort=0, light_fault=0. Synchroniser, debounce counter and lights history (l_q) clear to 0.
- Button path: 2-flop synchroniser, then a saturating debounce counter. btn_db rises after DEBOUNCE_CYCLES consecutive synchronised-high samples and falls on the first low sample. A btn_db rising edge sets req_pending. Holding the button generates one request.
- Lights history: l_q <= lights every cycle. red_rise = (lights==3'b100) && (l_q!=3'b100), combinational.
- Fault: any lights value other than 3'b001, 3'b010 or 3'b100 sets light_fault at the next edge. light_fault is sticky until reset. While set, state is forced to IDLE, walk=0, dont_walk=1, flash=0 and countdown=0. Requests may still latch.
- FSM states: IDLE, WALK, CLEAR.
  - IDLE -> WALK at the edge where red_rise && req_pending && !fault. On entry: countdown=WALK_CYCLES+FLASH_CYCLES-1 and req_pending clears. A request arriving mid-RED waits for the next red_rise.
  - WALK: walk=1, dont_walk=0. countdown decrements by 1 per cycle. After WALK_CYCLES cycles -> CLEAR.
  - CLEAR: walk=0, flash=1. dont_walk starts at 1 on the first CLEAR cycle and toggles every cycle. countdown keeps decrementing and reaches 0 in the last CLEAR cycle. After FLASH_CYCLES cycles -> IDLE with dont_walk=1 and countdown=0.
- Abort: if lights!=3'b100 at any edge while in WALK or CLEAR, the next state is IDLE and abort=1 for exactly one cycle. An abort caused by an illegal code also sets light_fault.
- Simultaneous events: a btn_db rising edge on the same edge as the IDLE->WALK entry leaves req_pending=1 (set wins over clear). Presses during WALK/CLEAR latch for the next red phase.
- countdown never wraps below 0. Outputs are registered; latency from red_rise to walk=1 is one cycle.

Test Plan:
1. Reset, pulse ped_btn high for 2 cycles (DEBOUNCE_CYCLES=3) -> req_pending stays 0.
2. Hold ped_btn 10 cycles during GREEN -> req_pending=1 once. Lights go 010->100 -> next cycle walk=1, countdown=4. Following cycles: countdown 3; then CLEAR with countdown 2,1,0, dont_walk 1,0,1 and flash=1. Then IDLE with dont_walk=1 and req_pending=0.
3. Request raised on the 2nd RED cycle -> no WALK in that RED. WALK starts one cycle after the next 010->100 transition.
4. Lights switch 100->001 on the 1st CLEAR cycle -> abort=1 for one cycle, then IDLE with walk=0, flash=0, countdown=0, dont_walk=1.
5. Drive lights=3'b110 for one cycle, then legal codes -> light_fault=1 and stays 1. Later RED with req_pending=1 produces no WALK until rst_n pulses low.
6. Assert rst_n low mid-WALK (asynchronous, between edges) -> outputs take their reset values immediately without a clock edge.

Source files
------------

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: latches a debounced button request and grants a
// WALK / flashing-clearance crossing only inside a vehicle RED phase.
module ped_crossing_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 3,
    parameter int unsigned WALK_CYCLES     = 2,
    parameter int unsigned FLASH_CYCLES    = 3,
    parameter int unsigned CNT_W           = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       lights,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             flash,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort,
    output logic             light_fault
);
    localparam int unsigned      DbW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DbW-1:0]   DbMax    = DbW'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CntStart = CNT_W'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntFlash = CNT_W'(FLASH_CYCLES);
    localparam logic [2:0]       LRed     = 3'b100;
    localparam logic [2:0]       LYel     = 3'b010;
    localparam logic [2:0]       LGrn     = 3'b001;

    typedef enum logic [1:0] {StIdle, StWalk, StClear} state_e;

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DbW-1:0]   db_cnt_q, db_cnt_d;
    logic [2:0]       l_q;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             flash_q, flash_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             abort_q, abort_d;
    logic             fault_q, fault_d;
    logic             btn_rise, is_red, illegal, red_rise, grant;

    assign is_red   = (lights == LRed);
    assign illegal  = !((lights == LRed) || (lights == LYel) || (lights == LGrn));
    assign red_rise = is_red && (l_q != LRed);

    // Saturating run-length of synchronised-high samples; a press is accepted once.
    always_comb begin
        db_cnt_d = '0;
        if (sync2_q) begin
            db_cnt_d = (db_cnt_q == DbMax) ? DbMax : db_cnt_q + 1'b1;
        end
    end
    assign btn_rise = (db_cnt_d == DbMax) && (db_cnt_q != DbMax);

    always_comb begin
        state_d     = state_q;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        flash_d     = 1'b0;
        cnt_d       = '0;
        abort_d     = 1'b0;
        grant       = 1'b0;
        fault_d     = fault_q | illegal;

        if (fault_q) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (red_rise && req_q) begin
                        grant   = 1'b1;
                        state_d = StWalk;
                    end
                end
                StWalk: begin
                    if (!is_red) begin
                        abort_d = 1'b1;
                        state_d = StIdle;
                    end else if (cnt_q == CntFlash) begin
                        state_d = StClear;
                    end
                end
                StClear: begin
                    if (!is_red) begin
                        abort_d = 1'b1;
                        state_d = StIdle;
                    end else if (cnt_q == '0) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Lamps are registered, so they are derived from the state being entered.
        unique case (state_d)
            StWalk: begin
                walk_d      = 1'b1;
                dont_walk_d = 1'b0;
                cnt_d       = (state_q == StIdle) ? CntStart : cnt_q - 1'b1;
            end
            StClear: begin
                flash_d     = 1'b1;
                dont_walk_d = (state_q == StClear) ? !dont_walk_q : 1'b1;
                cnt_d       = cnt_q - 1'b1;
            end
            default: ;
        endcase

        // A fresh press on the grant edge survives the clear.
        req_d = (req_q & ~grant) | btn_rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            db_cnt_q    <= '0;
            l_q         <= 3'b000;
            state_q     <= StIdle;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            flash_q     <= 1'b0;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            abort_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= ped_btn;
            sync2_q     <= sync1_q;
            db_cnt_q    <= db_cnt_d;
            l_q         <= lights;
            state_q     <= state_d;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            flash_q     <= flash_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            abort_q     <= abort_d;
            fault_q     <= fault_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign flash       = flash_q;
    assign countdown   = cnt_q;
    assign req_pending = req_q;
    assign abort       = abort_q;
    assign light_fault = fault_q;

endmodule
